// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC sequencer: time-shares one external cordic_stage
// over ITERS micro-rotations per angle, with valid/ready on both sides.
module cordic_iter_ctrl #(
  parameter int               ITERS  = 16,
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] K_INIT = 16'h26DD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] theta_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out,
  output logic             stg_valid,
  output logic [WIDTH-1:0] stg_k,
  output logic [WIDTH-1:0] stg_c,
  output logic [WIDTH-1:0] stg_x,
  output logic [WIDTH-1:0] stg_y,
  output logic [WIDTH-1:0] stg_z,
  input  logic             stg_valid_out,
  input  logic [WIDTH-1:0] stg_x_out,
  input  logic [WIDTH-1:0] stg_y_out,
  input  logic [WIDTH-1:0] stg_z_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]       iter_q, iter_d;

  // atan(2^-i) in Q2.14
  function automatic logic [WIDTH-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 16'd12868;
      4'd1:    atan_lut = 16'd7596;
      4'd2:    atan_lut = 16'd4014;
      4'd3:    atan_lut = 16'd2037;
      4'd4:    atan_lut = 16'd1023;
      4'd5:    atan_lut = 16'd512;
      4'd6:    atan_lut = 16'd256;
      4'd7:    atan_lut = 16'd128;
      4'd8:    atan_lut = 16'd64;
      4'd9:    atan_lut = 16'd32;
      4'd10:   atan_lut = 16'd16;
      4'd11:   atan_lut = 16'd8;
      4'd12:   atan_lut = 16'd4;
      4'd13:   atan_lut = 16'd2;
      4'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = K_INIT;
          y_d     = '0;
          z_d     = theta_in;
          iter_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // stage latency is not assumed; wait for its valid as long as needed
        if (stg_valid_out) begin
          x_d = stg_x_out;
          y_d = stg_y_out;
          z_d = stg_z_out;
          if (iter_q == 4'(ITERS - 1)) begin
            state_d = DONE;
          end else begin
            iter_d  = iter_q + 4'd1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign cos_out   = x_q;
  assign sin_out   = y_q;

  assign stg_valid = (state_q == ISSUE);
  assign stg_k     = {12'b0, iter_q};
  assign stg_c     = atan_lut(iter_q);
  assign stg_x     = x_q;
  assign stg_y     = y_q;
  assign stg_z     = z_q;

endmodule
